// File: rtl/imem_axil_pkg.sv
// Shared types and constants for the instruction-memory AXI4-Lite read responder.
package imem_axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } rsp_state_e;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  // 8-bit Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3).
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Word-addressed instruction RAM: synchronous write, asynchronous read, no reset.
module imem_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_axil_rd_responder.sv
// AXI4-Lite AR/R responder over a preloadable instruction RAM with programmable latency.
// Optional random stall injection is enabled by defining IMEM_STALL_INJECT_EN.
module imem_axil_rd_responder
  import imem_axil_pkg::*;
#(
  parameter int unsigned          IMADDRLEN  = 32,
  parameter int unsigned          IMDATALEN  = 32,
  parameter int unsigned          DEPTH      = 1024,
  parameter logic [IMADDRLEN-1:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned          RD_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [IMADDRLEN-1:0]     araddr,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [IMDATALEN-1:0]     rdata,
  output logic [1:0]               rresp,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [IMDATALEN-1:0]     ld_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(RD_LATENCY + 4) + 1;

  rsp_state_e state, state_nxt, acc_state;
  logic [CW-1:0] cnt, cnt_nxt, acc_cnt, total_lat;
  logic          ready_en;
  logic          ar_hs, r_hs, ar_gate;
  logic [1:0]    extra;

  logic [IMADDRLEN-1:0] offset, word_idx;
  logic                 out_of_range, misaligned;
  logic [IMDATALEN-1:0] ram_rdata, dec_data, hold_data;
  resp_e                dec_resp, hold_resp;

  imem_ram #(
    .DEPTH(DEPTH),
    .WIDTH(IMDATALEN)
  ) u_ram (
    .clk  (clk),
    .we   (ld_en),
    .waddr(ld_addr),
    .wdata(ld_data),
    .raddr(word_idx[AW-1:0]),
    .rdata(ram_rdata)
  );

`ifdef IMEM_STALL_INJECT_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign ar_gate = lfsr[0];
  assign extra   = lfsr[2:1];
`else
  assign ar_gate = 1'b0;
  assign extra   = '0;
`endif

  // Holds arready low through reset and the first clock after deassert.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) ready_en <= 1'b0;
    else       ready_en <= 1'b1;
  end

  always_comb begin
    arready = 1'b0;
    if (ready_en) begin
      unique case (state)
        IDLE:    arready = !ar_gate;
        WAIT:    arready = 1'b0;
        RESP:    arready = rready;
        default: arready = 1'b0;
      endcase
    end
  end

  assign rvalid = (state == RESP);
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;

  // Full-width subtraction: addresses below BASE_ADDR land far out of range.
  always_comb begin
    offset       = araddr - BASE_ADDR;
    word_idx     = offset >> 2;
    out_of_range = (araddr < BASE_ADDR) || (word_idx >= IMADDRLEN'(DEPTH));
    misaligned   = |araddr[1:0];
    if (out_of_range)    dec_resp = DECERR;
    else if (misaligned) dec_resp = SLVERR;
    else                 dec_resp = OKAY;
    dec_data = (dec_resp == OKAY) ? ram_rdata : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hold_data <= '0;
      hold_resp <= OKAY;
    end else if (ar_hs) begin
      hold_data <= dec_data;
      hold_resp <= dec_resp;
    end
  end

  assign rdata = hold_data;
  assign rresp = hold_resp;

  // Stall cycles fold into the total; a total of one goes straight to RESP.
  always_comb begin
    total_lat = CW'(RD_LATENCY) + CW'(extra);
    if (total_lat == CW'(1)) begin
      acc_state = RESP;
      acc_cnt   = '0;
    end else begin
      acc_state = WAIT;
      acc_cnt   = total_lat - CW'(2);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (ar_hs) begin
          state_nxt = acc_state;
          cnt_nxt   = acc_cnt;
        end
      end
      WAIT: begin
        if (cnt == '0) state_nxt = RESP;
        else           cnt_nxt   = cnt - CW'(1);
      end
      RESP: begin
        if (r_hs) begin
          if (ar_hs) begin
            state_nxt = acc_state;
            cnt_nxt   = acc_cnt;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_imem_axil_rd_responder.sv
// Self-checking bench: two responders (latency 1 and 3) against a queue-based read model.
module tb_imem_axil_rd_responder;

  localparam int DEPTH = 1024;
  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef IMEM_STALL_INJECT_EN
  localparam int SLACK = 3;
`else
  localparam int SLACK = 0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          acc;
    int          vld;
  } ent_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [1:0]  arvalid = '0;
  logic [1:0]  rready = '0;
  logic [31:0] araddr [2];
  logic [1:0]  arready_w, rvalid_w;
  logic [31:0] rdata_w [2];
  logic [1:0]  rresp_w [2];
  logic        ld_en = 1'b0;
  logic [9:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  logic [31:0] mem [DEPTH];
  ent_t        eq [2][$];
  ent_t        lg [2][$];
  int          head_vld [2];
  int          kcyc = 0;
  bit          rst_prev = 1'b1;
  int          n_chk = 0;
  int          n_fail = 0;
  bit          done;

  logic [31:0] prog [4];
  logic [31:0] err_addr [5];
  logic [1:0]  err_resp [5];
  logic [31:0] err_data [5];

  always #5 clk = ~clk;

  imem_axil_rd_responder #(.IMADDRLEN(32), .IMDATALEN(32), .DEPTH(DEPTH),
                           .BASE_ADDR(BASE), .RD_LATENCY(1)) u_lat1 (
    .clk(clk), .rstn(rstn), .arvalid(arvalid[0]), .arready(arready_w[0]),
    .araddr(araddr[0]), .rvalid(rvalid_w[0]), .rready(rready[0]),
    .rdata(rdata_w[0]), .rresp(rresp_w[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  imem_axil_rd_responder #(.IMADDRLEN(32), .IMDATALEN(32), .DEPTH(DEPTH),
                           .BASE_ADDR(BASE), .RD_LATENCY(3)) u_lat3 (
    .clk(clk), .rstn(rstn), .arvalid(arvalid[1]), .arready(arready_w[1]),
    .araddr(araddr[1]), .rvalid(rvalid_w[1]), .rready(rready[1]),
    .rdata(rdata_w[1]), .rresp(rresp_w[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, kcyc);
    end
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Read semantics straight from the address map.
  function automatic ent_t model_rd(input logic [31:0] a);
    ent_t e;
    e.data = '0;
    e.acc  = 0;
    e.vld  = -1;
    if (a < BASE || ((a - BASE) / 4) >= DEPTH) e.resp = 2'b11;
    else if ((a % 4) != 0)                      e.resp = 2'b10;
    else begin
      e.resp = 2'b00;
      e.data = mem[int'((a - BASE) / 4)];
    end
    return e;
  endfunction

  always @(negedge clk) begin
    ent_t e;
    bit   has;
    int   due;
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        eq[i].delete();
        head_vld[i] = -1;
        chk("rst_rvalid", 32'(rvalid_w[i]), 0);
        chk("rst_arready", 32'(arready_w[i]), 0);
        chk("rst_rdata", rdata_w[i], 0);
        chk("rst_rresp", 32'(rresp_w[i]), 0);
      end else begin
        has = eq[i].size() != 0;
        due = has ? eq[i][0].acc + lat_of(i) : 0;
        if (!has || kcyc < due)        chk("rvalid_early", 32'(rvalid_w[i]), 0);
        else if (kcyc >= due + SLACK)  chk("rvalid_late", 32'(rvalid_w[i]), 1);
        if (rvalid_w[i] && has) begin
          if (head_vld[i] < 0) head_vld[i] = kcyc;
          chk("rdata", rdata_w[i], eq[i][0].data);
          chk("rresp", 32'(rresp_w[i]), 32'(eq[i][0].resp));
        end
`ifdef IMEM_STALL_INJECT_EN
        if (arready_w[i])
          chk("arready_allowed", 32'(!rst_prev && (!has || (rvalid_w[i] && rready[i]))), 1);
`else
        chk("arready", 32'(arready_w[i]), 32'(!rst_prev && (!has || (kcyc >= due && rready[i]))));
`endif
        if (rvalid_w[i] && rready[i] && has) begin
          e = eq[i][0];
          e.vld = head_vld[i];
          lg[i].push_back(e);
          eq[i].pop_front();
          head_vld[i] = -1;
        end
        if (arvalid[i] && arready_w[i]) begin
          e = model_rd(araddr[i]);
          e.acc = kcyc;
          eq[i].push_back(e);
        end
      end
    end
    if (ld_en) mem[ld_addr] = ld_data;
    rst_prev = !rstn;
    kcyc++;
  end

  task automatic issue_ar(input int i, input logic [31:0] a);
    int n = 0;
    arvalid[i] = 1'b1;
    araddr[i]  = a;
    forever begin
      @(negedge clk);
      if (arready_w[i]) break;
      n++;
      if (n > 60) begin
        n_chk++;
        n_fail++;
        $display("FAIL ar_timeout: dut %0d addr %h never accepted", i, a);
        break;
      end
    end
    @(posedge clk);
    #1;
    arvalid[i] = 1'b0;
  endtask

  task automatic load(input int idx, input logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = 10'(idx);
    ld_data = d;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
  endtask

  task automatic drain(input int i);
    int n = 0;
    while (eq[i].size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_empty", 32'(eq[i].size()), 0);
  endtask

  task automatic wait_valid(input int i);
    int n = 0;
    while (!rvalid_w[i] && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("wait_valid", 32'(rvalid_w[i]), 1);
  endtask

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation did not finish");
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    prog = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193};
    err_addr = '{32'h0000_0006, 32'h0000_1000, 32'h0000_1002, 32'h0000_0FFC, 32'hFFFF_FFFC};
    err_resp = '{2'b10, 2'b11, 2'b11, 2'b00, 2'b11};
    err_data = '{32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 32'h0};
    araddr[0] = '0;
    araddr[1] = '0;
    head_vld[0] = -1;
    head_vld[1] = -1;
    #2 rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    chk("arready_first_cycle", 32'(arready_w), 0);
    @(posedge clk);
    #1;
`ifndef IMEM_STALL_INJECT_EN
    chk("arready_after_enable", 32'(arready_w), 32'h3);
`endif
    for (int k = 0; k < 4; k++)  load(k, prog[k]);
    for (int k = 4; k < 16; k++) load(k, 32'hA000_0000 + 32'(k));
    load(1023, 32'hCAFE_F00D);

    // back-to-back reads at latency 1
    rready = 2'b11;
    lg[0].delete();
    for (int k = 0; k < 4; k++) issue_ar(0, 32'(k * 4));
    drain(0);
    chk("b2b_count", 32'(lg[0].size()), 4);
    if (lg[0].size() == 4) begin
      for (int k = 0; k < 4; k++) begin
        chk("b2b_data", lg[0][k].data, prog[k]);
        chk("b2b_resp", 32'(lg[0][k].resp), 0);
`ifndef IMEM_STALL_INJECT_EN
        chk("b2b_consecutive", 32'(lg[0][k].vld - lg[0][0].vld), 32'(k));
        chk("b2b_latency", 32'(lg[0][k].vld - lg[0][k].acc), 1);
`endif
      end
    end

    // latency 3 with held rready, plus a pending AR while busy
    lg[1].delete();
    rready[1] = 1'b0;
    issue_ar(1, 32'h4);
`ifndef IMEM_STALL_INJECT_EN
    chk("wait_arready", 32'(arready_w[1]), 0);
`endif
    wait_valid(1);
    arvalid[1] = 1'b1;
    araddr[1]  = 32'hC;
    repeat (5) begin
      @(negedge clk);
      chk("hold_rdata", rdata_w[1], 32'h00100093);
      chk("hold_rresp", 32'(rresp_w[1]), 0);
      chk("hold_arready", 32'(arready_w[1]), 0);
    end
    @(posedge clk);
    #1 rready[1] = 1'b1;
    issue_ar(1, 32'hC);
    drain(1);
    chk("lat3_count", 32'(lg[1].size()), 2);
    if (lg[1].size() == 2) begin
      chk("lat3_data0", lg[1][0].data, 32'h00100093);
      chk("lat3_data1", lg[1][1].data, 32'h00308193);
`ifndef IMEM_STALL_INJECT_EN
      chk("lat3_latency", 32'(lg[1][0].vld - lg[1][0].acc), 3);
`endif
    end

    // error decode
    lg[0].delete();
    for (int k = 0; k < 5; k++) issue_ar(0, err_addr[k]);
    drain(0);
    chk("err_count", 32'(lg[0].size()), 5);
    if (lg[0].size() == 5) begin
      for (int k = 0; k < 5; k++) begin
        chk("err_resp", 32'(lg[0][k].resp), 32'(err_resp[k]));
        chk("err_data", lg[0][k].data, err_data[k]);
      end
    end

    // load colliding with accept, then load after accept
    lg[0].delete();
    ld_en = 1'b1;
    ld_addr = 10'd2;
    ld_data = 32'hDEADBEEF;
    issue_ar(0, 32'h8);
    ld_en = 1'b0;
    issue_ar(0, 32'h8);
    drain(0);
    if (lg[0].size() == 2) begin
`ifndef IMEM_STALL_INJECT_EN
      chk("ld_collide_old", lg[0][0].data, 32'h00200113);
`endif
      chk("ld_next_new", lg[0][1].data, 32'hDEADBEEF);
    end
    lg[1].delete();
    issue_ar(1, 32'h10);
    load(4, 32'h5555_AAAA);
    drain(1);
    if (lg[1].size() == 1) chk("inflight_unchanged", lg[1][0].data, 32'hA000_0004);

    // reset mid-operation
    rready = 2'b00;
    issue_ar(0, 32'h8);
    wait_valid(0);
    issue_ar(1, 32'h0);
`ifndef IMEM_STALL_INJECT_EN
    chk("pre_rst_wait", 32'(rvalid_w[1]), 0);
`endif
    #1 rstn = 1'b0;
    #1;
    chk("rst_async_rvalid0", 32'(rvalid_w[0]), 0);
    chk("rst_async_rvalid1", 32'(rvalid_w[1]), 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    chk("rst_arready_first", 32'(arready_w[1]), 0);
    rready = 2'b11;
    lg[1].delete();
    issue_ar(1, 32'h0);
    drain(1);
    chk("rst_retain_count", 32'(lg[1].size()), 1);
    if (lg[1].size() == 1) chk("rst_retain_data", lg[1][0].data, 32'h00000013);

    // random aligned reads with random backpressure
    for (int i = 0; i < 2; i++) begin
      lg[i].delete();
      done = 1'b0;
      fork
        begin
          for (int n = 0; n < 200; n++) issue_ar(i, 32'($urandom_range(0, 15)) << 2);
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(posedge clk);
            #1 rready[i] = ($urandom_range(0, 3) != 0);
          end
        end
      join
      rready[i] = 1'b1;
      drain(i);
      chk("rand_count", 32'(lg[i].size()), 200);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_axil_rd_responder.md
Name: imem_axil_rd_responder

Overview:
- AXI4-Lite read-channel responder: the instruction-memory side that answers the core's fetch read requests on the AR and R channels.
- Holds a word-addressed instruction RAM.
- The bench preloads the RAM through a simple load port.
- Returns fetched words after a programmable latency.
- At most one read is outstanding at a time. Back-to-back reads are supported.

Parameters:
- IMADDRLEN, 32, width of araddr.
- IMDATALEN, 32, width of rdata and of each RAM word.
- DEPTH, 1024, number of RAM words. Must be a power of 2.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- RD_LATENCY, 1, cycles from AR handshake to rvalid. Must be >= 1.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- arvalid  in  1  read-address valid
- arready  out  1  read-address ready
- araddr  in  IMADDRLEN  byte address
- rvalid  out  1  read-data valid
- rready  in  1  read-data ready
- rdata  out  IMDATALEN  read data
- rresp  out  2  response code: 00 OKAY, 10 SLVERR, 11 DECERR
- ld_en  in  1  RAM load strobe
- ld_addr  in  $clog2(DEPTH)  word index to load
- ld_data  in  IMDATALEN  word to load

Behaviour:
- Clock and reset: single clock domain, clk. rstn is asynchronous assert, synchronous deassert by the system.
- Reset values:
  - rvalid=0, rdata=0, rresp=00, state=IDLE, latency counter=0.
  - arready=0 while rstn is low and in the first cycle after deassert; a registered ready_en flop sets on that first clock.
  - RAM contents are not reset.
- State machine:
  - IDLE: arready=1.
  - WAIT: arready=0.
  - RESP: arready=rready.
- Transitions:
  - IDLE to WAIT on an AR handshake when RD_LATENCY>1. The counter loads RD_LATENCY-2.
  - IDLE to RESP on an AR handshake when RD_LATENCY==1.
  - WAIT decrements the counter and goes to RESP when it reaches 0.
  - RESP with an R handshake and no AR handshake: go to IDLE.
  - RESP with R and AR handshakes in the same cycle: treat as a new accept (WAIT or RESP per latency). rvalid may stay high continuously.
- Latency: AR handshake at edge t gives rvalid=1 at edge t+RD_LATENCY.
- Address decode at accept, with word index = (araddr-BASE_ADDR)>>2:
  - araddr[1:0]!=0: rresp=SLVERR, rdata=0.
  - araddr<BASE_ADDR or word index>=DEPTH: rresp=DECERR, rdata=0. DECERR takes priority over SLVERR.
  - Otherwise: rresp=OKAY, rdata=RAM[index].
  - The full IMADDRLEN-bit subtraction is used; no wrap into range.
- Data capture:
  - The RAM word is sampled into a holding register at the AR handshake edge.
  - The held word is presented on rvalid.
  - rdata and rresp stay stable while rvalid && !rready.
- Load port:
  - Synchronous write of RAM[ld_addr]=ld_data on the clock edge when ld_en=1.
  - Allowed in any state.
  - A load to the word being read in the same cycle as the AR handshake returns the OLD data.
  - A load after the accept does not change an in-flight response.
- arvalid while in WAIT: ignored (arready=0). The master holds it per protocol.
- Reset mid-operation: the outstanding response is dropped. rvalid drops immediately (asynchronous) and the block returns to IDLE. The RAM is preserved.

Optional Feature:
- Macro: IMEM_STALL_INJECT_EN.
- With the macro defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4) is reset to 8'hA5 and advances every cycle.
  - In IDLE, arready is additionally gated low when lfsr[0]=1.
  - At each accept, lfsr[2:1] extra cycles (0-3) are added to the WAIT count. With RD_LATENCY==1 and extra>0, the block enters WAIT.
- Without the macro:
  - Latency is exactly RD_LATENCY.
  - arready follows the state rule only.
  - No LFSR logic is present.

Decomposition:
- Package imem_axil_pkg:
  - resp_e enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - rsp_state_e enum: IDLE, WAIT, RESP.
  - LFSR_SEED = 8'hA5.
- Sub-module imem_ram: DEPTH x IMDATALEN array, synchronous write port, asynchronous read port. The top level instantiates one.

Test Plan:
- Reset, then load RAM[0..3]=32'h00000013, 32'h00100093, 32'h00200113, 32'h00308193. With RD_LATENCY=1, issue AR 0x0, 0x4, 0x8, 0xC and hold rready=1 -> back-to-back rvalid, 4 responses in 4 consecutive cycles, data in order, rresp=00.
- RD_LATENCY=3; AR 0x4 accepted at cycle 10 -> rvalid rises at cycle 13 with rdata 32'h00100093. Hold rready=0 for 5 cycles -> rdata/rresp stable, arready=0 throughout.
- AR 0x6 -> rresp=10, rdata=0. AR 0x1000 with DEPTH=1024 -> rresp=11, rdata=0. AR 0x1002 -> rresp=11 (DECERR priority).
- AR 0x8 and ld_en to index 2 with 32'hDEADBEEF in the same cycle -> response 32'h00200113. The next read of 0x8 returns 32'hDEADBEEF.
- rstn pulsed low while in WAIT -> rvalid=0 immediately, arready=0 for one cycle after deassert. A following read of 0x0 returns 32'h00000013 (RAM retained).
- With IMEM_STALL_INJECT_EN: issue 200 random aligned reads -> every response matches the RAM model in order, latency lies in RD_LATENCY..RD_LATENCY+3, and no protocol violation occurs.
